// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch flushes, cache-miss freezes.
// Optional HAZARD_STATS_EN adds saturating stat_lu / stat_miss event counters.
module pipe_hazard_ctrl #(
    parameter int MISS_TIMEOUT = 64,
    parameter int REG_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_load,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             halted
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]      stat_lu,
    output logic [15:0]      stat_miss
`endif
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MISS = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_8 = 8'(MISS_TIMEOUT);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_timer;
    logic [7:0] w_timer_next;
    logic       w_miss;
    logic       w_lu;
    logic       w_bubble;

    assign w_miss = mem_req & ~mem_ready;
    assign w_lu   = idex_load && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_timer <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_write   = 1'b0;
        idex_flush   = 1'b0;
        exmem_write  = 1'b0;
        halted       = 1'b0;
        w_bubble     = 1'b0;
        case (r_state)
            RUN: begin
                w_timer_next = 8'd0;
                if (w_miss) begin
                    w_state_next = MISS;
                    w_timer_next = 8'd1;
                end else if (w_lu) begin
                    // Branch is ignored here; it is still pending in ID after the bubble.
                    idex_flush  = 1'b1;
                    idex_write  = 1'b1;
                    exmem_write = 1'b1;
                    w_bubble    = 1'b1;
                end else begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    idex_write  = 1'b1;
                    exmem_write = 1'b1;
                    ifid_flush  = branch_taken;
                end
            end
            MISS: begin
                // Timer holds the index of the current MISS cycle.
                if (mem_ready || !mem_req) begin
                    w_state_next = RUN;
                    w_timer_next = 8'd0;
                end else if (r_timer >= TIMEOUT_8) begin
                    w_state_next = HALT;
                end else if (r_timer != 8'hFF) begin
                    w_timer_next = r_timer + 8'd1;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_next = RUN;
                w_timer_next = 8'd0;
            end
        endcase
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] r_stat_lu;
    logic [15:0] r_stat_miss;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_lu   <= 16'd0;
            r_stat_miss <= 16'd0;
        end else begin
            if (w_bubble && (r_stat_lu != 16'hFFFF))
                r_stat_lu <= r_stat_lu + 16'd1;
            if ((r_state == MISS) && (r_stat_miss != 16'hFFFF))
                r_stat_miss <= r_stat_miss + 16'd1;
        end
    end

    assign stat_lu   = r_stat_lu;
    assign stat_miss = r_stat_miss;
`endif

endmodule
